// File: rtl/ram_pkg.sv
// Shared defaults and state encoding for the RAM arbiter slice.
package ram_pkg;

  localparam int unsigned RAM_A_DEF = 10;
  localparam int unsigned RAM_D_DEF = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: first requester strictly above i_last,
// wrapping to the lowest requester when none is above.
module rr_select #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick;
  logic         w_found;

  always_comb begin
    w_hi = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_hi[i] = i_req[i] && (i > 32'(i_last));
    end
    // Requests above the last winner take precedence; otherwise wrap around.
    w_pick  = (|w_hi) ? w_hi : i_req;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_pick[i] && !w_found) begin
        w_found  = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// N-way round-robin arbiter with bus lock in front of a single-port RAM.
// Grant is combinational; read data is tagged one cycle later by rvalid.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int unsigned A = RAM_A_DEF,
  parameter int unsigned D = RAM_D_DEF,
  parameter int unsigned N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   rw,
  input  logic [N*A-1:0] addr,
  input  logic [N*D-1:0] wdata,
  input  logic [N-1:0]   lock,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   rvalid,
  output logic [D-1:0]   rdata,
  output logic           ram_cs,
  output logic           ram_rw,
  output logic [A-1:0]   ram_addr,
  output logic [D-1:0]   ram_wdata,
  input  logic [D-1:0]   ram_rdata
);

  localparam int unsigned IW = $clog2(N);

  arb_state_t    r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_last;
  logic [N-1:0]  r_rvalid;

  logic [N-1:0]  w_rr_gnt;
  logic [IW-1:0] w_rr_idx;
  logic [N-1:0]  w_own_oh;
  logic [N-1:0]  w_gnt;
  logic [IW-1:0] w_idx;
  logic          w_keep;
  logic          w_any;
  logic          w_rd;
  logic          w_lock_win;

  rr_select #(
    .N  (N),
    .IW (IW)
  ) u_rr (
    .i_req  (req),
    .i_last (r_last),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx)
  );

  always_comb begin
    w_own_oh = N'(1) << r_owner;
    // Owner keeps the bus only while it both requests and holds lock.
    w_keep   = (r_state == LOCKED) && (|(w_own_oh & req & lock));
    w_gnt    = '0;
    w_idx    = w_rr_idx;
    if (rst_n) begin
      if (w_keep) begin
        w_gnt = w_own_oh;
        w_idx = r_owner;
      end else begin
        w_gnt = w_rr_gnt;
      end
    end
    w_any      = |w_gnt;
    w_rd       = |(w_gnt & rw);
    w_lock_win = |(w_gnt & lock);
  end

  always_comb begin
    ram_cs    = w_any;
    ram_rw    = 1'b1;
    ram_addr  = '0;
    ram_wdata = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt[i]) begin
        ram_rw    = rw[i];
        ram_addr  = addr[i*A +: A];
        ram_wdata = wdata[i*D +: D];
      end
    end
  end

  always_comb begin
    gnt    = w_gnt;
    rvalid = r_rvalid;
    rdata  = ram_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_last   <= IW'(N - 1);
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_rd ? w_gnt : '0;
      if (w_any) begin
        r_last <= w_idx;
      end
      if (w_keep) begin
        r_state <= LOCKED;
      end else if (w_lock_win) begin
        r_state <= LOCKED;
        r_owner <= w_idx;
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed table-driven bench for ram_arbiter (N=2) with a behavioural
// synchronous RAM attached at the level above the arbiter.
module tb_ram_arbiter;

  localparam int unsigned A = 10;
  localparam int unsigned D = 8;
  localparam int unsigned N = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   rw;
  logic [N*A-1:0] addr;
  logic [N*D-1:0] wdata;
  logic [N-1:0]   lock;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rvalid;
  logic [D-1:0]   rdata;
  logic           ram_cs;
  logic           ram_rw;
  logic [A-1:0]   ram_addr;
  logic [D-1:0]   ram_wdata;
  logic [D-1:0]   ram_rdata;

  ram_arbiter #(
    .A (A),
    .D (D),
    .N (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .rw        (rw),
    .addr      (addr),
    .wdata     (wdata),
    .lock      (lock),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .ram_cs    (ram_cs),
    .ram_rw    (ram_rw),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  logic [D-1:0] mem [0:(1<<A)-1];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_rw) ram_rdata <= mem[ram_addr];
      else        mem[ram_addr] <= ram_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req, rw, lock;
    logic [9:0] a0, a1;
    logic [7:0] w0, w1;
    logic [1:0] e_gnt;
    logic       e_cs, e_rrw;
    logic [9:0] e_addr;
    logic [7:0] e_wd;
    logic [1:0] e_rv;
    logic [7:0] e_rd;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    //          req    rw     lock   a0       a1       w0     w1       gnt    cs    rrw   addr     wd     rv     rd
    tv[0]  = '{2'b01, 2'b01, 2'b00, 10'h005, 10'h000, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1, 10'h005, 8'h00, 2'b00, 8'h00};
    tv[1]  = '{2'b10, 2'b00, 2'b00, 10'h000, 10'h3FF, 8'h00, 8'h3C, 2'b10, 1'b1, 1'b0, 10'h3FF, 8'h3C, 2'b01, 8'hA5};
    tv[2]  = '{2'b01, 2'b01, 2'b00, 10'h3FF, 10'h000, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1, 10'h3FF, 8'h00, 2'b00, 8'h00};
    tv[3]  = '{2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 10'h000, 8'h00, 2'b01, 8'h3C};
    tv[4]  = '{2'b10, 2'b10, 2'b00, 10'h000, 10'h011, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 10'h011, 8'h00, 2'b00, 8'h00};
    tv[5]  = '{2'b11, 2'b11, 2'b00, 10'h010, 10'h011, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1, 10'h010, 8'h00, 2'b10, 8'h22};
    tv[6]  = '{2'b11, 2'b11, 2'b00, 10'h010, 10'h011, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 10'h011, 8'h00, 2'b01, 8'h11};
    tv[7]  = '{2'b11, 2'b11, 2'b00, 10'h010, 10'h011, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1, 10'h010, 8'h00, 2'b10, 8'h22};
    tv[8]  = '{2'b11, 2'b11, 2'b00, 10'h010, 10'h011, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 10'h011, 8'h00, 2'b01, 8'h11};
    tv[9]  = '{2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 10'h000, 8'h00, 2'b10, 8'h22};
    tv[10] = '{2'b01, 2'b00, 2'b00, 10'h020, 10'h000, 8'h5A, 8'h00, 2'b01, 1'b1, 1'b0, 10'h020, 8'h5A, 2'b00, 8'h00};
    tv[11] = '{2'b11, 2'b00, 2'b10, 10'h030, 10'h031, 8'h01, 8'h02, 2'b10, 1'b1, 1'b0, 10'h031, 8'h02, 2'b00, 8'h00};
    tv[12] = '{2'b11, 2'b00, 2'b10, 10'h030, 10'h031, 8'h01, 8'h02, 2'b10, 1'b1, 1'b0, 10'h031, 8'h02, 2'b00, 8'h00};
    tv[13] = '{2'b11, 2'b00, 2'b10, 10'h030, 10'h031, 8'h01, 8'h02, 2'b10, 1'b1, 1'b0, 10'h031, 8'h02, 2'b00, 8'h00};
    tv[14] = '{2'b11, 2'b00, 2'b00, 10'h030, 10'h031, 8'h01, 8'h02, 2'b01, 1'b1, 1'b0, 10'h030, 8'h01, 2'b00, 8'h00};
    tv[15] = '{2'b11, 2'b00, 2'b00, 10'h030, 10'h031, 8'h01, 8'h02, 2'b10, 1'b1, 1'b0, 10'h031, 8'h02, 2'b00, 8'h00};
    tv[16] = '{2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 10'h000, 8'h00, 2'b00, 8'h00};
    tv[17] = '{2'b01, 2'b01, 2'b01, 10'h010, 10'h000, 8'h00, 8'h00, 2'b01, 1'b1, 1'b1, 10'h010, 8'h00, 2'b00, 8'h00};
    tv[18] = '{2'b11, 2'b00, 2'b01, 10'h040, 10'h041, 8'h77, 8'h88, 2'b01, 1'b1, 1'b0, 10'h040, 8'h77, 2'b01, 8'h11};
    tv[19] = '{2'b10, 2'b10, 2'b01, 10'h000, 10'h011, 8'h00, 8'h00, 2'b10, 1'b1, 1'b1, 10'h011, 8'h00, 2'b00, 8'h00};
    tv[20] = '{2'b00, 2'b00, 2'b00, 10'h000, 10'h000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1, 10'h000, 8'h00, 2'b10, 8'h22};

    mem[10'h005] <= 8'hA5;
    mem[10'h010] <= 8'h11;
    mem[10'h011] <= 8'h22;

    // Reset state with requests already pending
    rst_n = 1'b0;
    req   = 2'b11;
    rw    = 2'b11;
    lock  = 2'b11;
    addr  = '0;
    wdata = '0;
    #7;
    chk("reset gnt", 32'(gnt), 32'h0);
    chk("reset ram_cs", 32'(ram_cs), 32'h0);
    chk("reset ram_rw", 32'(ram_rw), 32'h1);
    chk("reset rvalid", 32'(rvalid), 32'h0);
    req  = '0;
    lock = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      req   = tv[i].req;
      rw    = tv[i].rw;
      lock  = tv[i].lock;
      addr  = {tv[i].a1, tv[i].a0};
      wdata = {tv[i].w1, tv[i].w0};
      @(negedge clk);
      chk($sformatf("v%0d gnt", i), 32'(gnt), 32'(tv[i].e_gnt));
      chk($sformatf("v%0d ram_cs", i), 32'(ram_cs), 32'(tv[i].e_cs));
      chk($sformatf("v%0d ram_rw", i), 32'(ram_rw), 32'(tv[i].e_rrw));
      if (tv[i].e_cs)
        chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tv[i].e_addr));
      if (tv[i].e_cs && !tv[i].e_rrw)
        chk($sformatf("v%0d ram_wdata", i), 32'(ram_wdata), 32'(tv[i].e_wd));
      chk($sformatf("v%0d rvalid", i), 32'(rvalid), 32'(tv[i].e_rv));
      if (tv[i].e_rv != 2'b00)
        chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(tv[i].e_rd));
      @(posedge clk);
      #1;
    end

    // Reset while requester 1 holds the lock with a read in flight
    req   = 2'b10;
    rw    = 2'b10;
    lock  = 2'b10;
    addr  = {10'h011, 10'h010};
    wdata = '0;
    @(negedge clk);
    chk("lockrd gnt", 32'(gnt), 32'h2);
    @(posedge clk);
    #1;
    chk("lockrd rvalid", 32'(rvalid), 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async rst gnt", 32'(gnt), 32'h0);
    chk("async rst rvalid", 32'(rvalid), 32'h0);
    chk("async rst ram_cs", 32'(ram_cs), 32'h0);
    chk("async rst ram_rw", 32'(ram_rw), 32'h1);
    @(posedge clk);
    #1;
    chk("held rst rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b11;
    rw    = 2'b11;
    lock  = 2'b10;
    #1;
    chk("post rst gnt", 32'(gnt), 32'h1);
    chk("post rst ram_addr", 32'(ram_addr), 32'h010);
    @(posedge clk);
    #1;
    chk("post rst rvalid", 32'(rvalid), 32'h1);
    chk("post rst rdata", 32'(rdata), 32'h11);
    chk("post rst next gnt", 32'(gnt), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001: Parameter A, default 10: address width, matching the RAM address width.
REQ-002: Parameter D, default 8: data width, matching the RAM data width.
REQ-003: Parameter N, default 2: number of requesters, 2..8.
REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006: req  input  N  per-requester access request, held until granted.
REQ-007: rw  input  N  per-requester direction; 1 = read, 0 = write (RAM convention).
REQ-008: addr  input  N x A  per-requester address.
REQ-009: wdata  input  N x D  per-requester write data.
REQ-010: lock  input  N  per-requester bus lock, keeps ownership while asserted.
REQ-011: gnt  output  N  one-hot combinational grant; access accepted in the same cycle.
REQ-012: rvalid  output  N  registered one-hot pulse flagging rdata for a read granted in the previous cycle.
REQ-013: rdata  output  D  read data, wired directly from ram_rdata.
REQ-014: ram_cs, ram_rw  output  1 each  RAM chip select and direction.
REQ-015: ram_addr  output  A; ram_wdata  output  D; ram_rdata  input  D  RAM port signals.

Function
REQ-016: At most one gnt bit SHALL be high per cycle; gnt SHALL be 0 when req is 0.
REQ-017: In a granted cycle, ram_cs=1 and ram_rw/ram_addr/ram_wdata SHALL equal the winner's rw/addr/wdata; otherwise ram_cs=0 and ram_rw=1.
REQ-018: Arbitration SHALL be round-robin: search starts at last_gnt+1 modulo N; the first requester with req=1 wins.
REQ-019: last_gnt SHALL update to the winner's index at every granted clock edge.
REQ-020: FSM states: IDLE (no owner) and LOCKED (owner index held in register).
REQ-021: IDLE -> LOCKED when the winner has lock=1 at its grant; the owner is recorded.
REQ-022: In LOCKED, if the owner has req=1, the owner SHALL win regardless of other requests.
REQ-023: LOCKED -> IDLE when the owner drops lock or req. In that same cycle, normal round-robin arbitration SHALL apply.
REQ-024: Read latency SHALL be 1 cycle: rvalid[i] is high exactly on the cycle after a granted read by i, and rdata is valid in that cycle.
REQ-025: Writes SHALL produce no rvalid pulse.
REQ-026: Back-to-back reads by different requesters SHALL produce consecutive rvalid pulses with the correct one-hot tags.
REQ-027: A requester SHALL wait at most N-1 grants while no lock is held.

Reset
REQ-028: While rst_n=0: gnt=0, ram_cs=0, ram_rw=1, rvalid=0, FSM=IDLE, last_gnt=N-1, so requester 0 has first priority.
REQ-029: Reset asserted mid-operation SHALL clear any lock and any pending rvalid immediately, with no RAM access issued.
REQ-030: The first grant SHALL occur at the first rising edge after rst_n deasserts.

Structure
REQ-031: A shared package ram_pkg SHALL hold the A/D defaults and the arbiter state enum (IDLE, LOCKED).
REQ-032: The round-robin priority selector SHALL be a sub-module rr_select, purely combinational, taking N-bit req and last index and returning a one-hot grant plus an index.
REQ-033: The arbiter SHALL instantiate no RAM; the RAM is connected at the level above.

Verification
REQ-034: Single read: req=01, rw[0]=1, addr[0]=0x005, RAM holds 0xA5 -> gnt=01 in cycle 0; rvalid=01 and rdata=0xA5 in cycle 1.
REQ-035: Contention without lock: req=11 held for 4 cycles -> gnt sequence 01,10,01,10.
REQ-036: Lock: req=11, lock[1]=1 for 3 cycles, starting with last_gnt=0 -> gnt=10 ×3. Then lock drops -> gnt=01 next cycle.
REQ-037: Write then read back: requester 1 writes 0x3C to 0x3FF, then requester 0 reads 0x3FF -> rvalid=01 with rdata=0x3C.
REQ-038: Reset mid-lock: rst_n pulled low while LOCKED with a read in flight -> gnt, rvalid and ram_cs go 0 asynchronously. After release, req=11 -> gnt=01 first.
